ca_stream_decrypt: RTL and testbench

Decrypts a byte stream using a hybrid cellular-automaton (CA) keystream generator; it is the receive-side counterpart of the CA encryption path. The block loads a seed into an N-cell CA register, runs a fixed number of warm-up steps, then XORs each accepted ciphertext byte with the low byte of the CA state and advances the CA by one step. Input and output use valid/ready handshakes. The block sits between the link receiver and the plaintext consumer.

---
 rtl/ca_stream_decrypt.sv | 131 +++++++++++++
 tb/tb_ca_stream_decrypt.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_stream_decrypt.sv
// Receive-side CA keystream decryptor: seeds an N-cell hybrid cellular automaton, warms it up,
// then XORs each accepted ciphertext byte with the low byte of the CA state.
module ca_stream_decrypt #(
    parameter int                   N_CELLS = 32,
    parameter int                   DATA_W  = 8,
    parameter int                   WARMUP  = 64,
    parameter logic [3*N_CELLS-1:0] RULES   = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_CELLS-1:0] seed,
    output logic               busy,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic               out_ready,
    output logic [1:0]         dbg_state
);

    // Handshakes: a beat transfers on a rising edge where valid && ready are both high.
    // in_ready depends combinationally on out_ready (one-deep output buffer) and start.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WARM = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    localparam int CNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP - 1);

    logic [1:0]         state_q, state_d;
    logic [N_CELLS-1:0] s_q, s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;

    logic [N_CELLS+1:0] s_pad;
    logic [N_CELLS-1:0] ca_next;
    logic               accept;

    function automatic logic rule_f(input logic [2:0] r, input logic a, input logic b,
                                    input logic c);
        logic y;
        case (r)
            3'b000:  y = a ^ b ^ c ^ (b & c);
            3'b001:  y = a ^ b;
            3'b010:  y = a ^ c;
            3'b011:  y = a ^ (b & c);
            3'b100:  y = a ^ b ^ c;
            3'b101:  y = a ^ b ^ (b & c);
            3'b110:  y = a ^ c ^ (b & c);
            default: y = a;
        endcase
        return y;
    endfunction

    // Zero padding on both ends gives the null boundary cells.
    assign s_pad = {1'b0, s_q, 1'b0};

    always_comb begin
        ca_next = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            ca_next[i] = rule_f(RULES[3*i +: 3], s_pad[i+1], s_pad[i], s_pad[i+2]);
        end
    end

    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready) && !start;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (start) begin
            // Seed is captured while start is high; LOAD then fixes up an all-zero seed.
            state_d     = ST_LOAD;
            s_d         = seed;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (s_q == '0) s_d = N_CELLS'(1);
                    cnt_d   = '0;
                    state_d = ST_WARM;
                end
                ST_WARM: begin
                    s_d   = ca_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (accept) begin
                        out_data_d  = in_data ^ s_q[DATA_W-1:0];
                        out_valid_d = 1'b1;
                        s_d         = ca_next;
                    end else if (out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ca_stream_decrypt.sv
// Bench for ca_stream_decrypt: three instances (mixed rules, rule 001 on 8 cells, rule 111)
// checked against a byte-stream keystream model and the directed vectors.
module tb_ca_stream_decrypt;

    localparam int NC[3] = '{32, 8, 32};
    localparam int WU[3] = '{64, 2, 1};
    localparam logic [95:0] RL[3] = '{96'h5A3C_96F1_0E7D_B248_C1A5_3F6E,
                                      {32{3'b001}}, {32{3'b111}}};
    // Which optional terms (b, c, b&c) each rule code XORs onto a, indexed by rule code.
    localparam logic [7:0] USE_B  = 8'b0011_0011;
    localparam logic [7:0] USE_C  = 8'b0101_0101;
    localparam logic [7:0] USE_BC = 8'b0110_1001;

    logic        clk;
    logic        rst_n;
    logic        st[3];
    logic [31:0] sd[3];
    logic        iv[3];
    logic [7:0]  id[3];
    logic        ordy[3];
    logic        bsy[3];
    logic        ir[3];
    logic        ov[3];
    logic [7:0]  od[3];
    logic [1:0]  dbg[3];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_s[3];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  src_q[$];

    ca_stream_decrypt #(.N_CELLS(32), .DATA_W(8), .WARMUP(64), .RULES(RL[0])) u_rand (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .seed(sd[0]), .busy(bsy[0]),
        .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir[0]), .out_valid(ov[0]),
        .out_data(od[0]), .out_ready(ordy[0]), .dbg_state(dbg[0]));

    ca_stream_decrypt #(.N_CELLS(8), .DATA_W(8), .WARMUP(2), .RULES(RL[1][23:0])) u_small (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .seed(sd[1][7:0]), .busy(bsy[1]),
        .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir[1]), .out_valid(ov[1]),
        .out_data(od[1]), .out_ready(ordy[1]), .dbg_state(dbg[1]));

    ca_stream_decrypt #(.N_CELLS(32), .DATA_W(8), .WARMUP(1), .RULES(RL[2])) u_const (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .seed(sd[2]), .busy(bsy[2]),
        .in_valid(iv[2]), .in_data(id[2]), .in_ready(ir[2]), .out_valid(ov[2]),
        .out_data(od[2]), .out_ready(ordy[2]), .dbg_state(dbg[2]));

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mask(input int k);
        return (NC[k] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NC[k]) - 32'd1);
    endfunction

    // One CA step: left neighbour vector is s<<1, right neighbour vector is s>>1.
    function automatic logic [31:0] model_step(input logic [31:0] s, input int k);
        logic [31:0] sl, sr, r;
        logic [2:0]  code;
        sl = (s << 1) & mask(k);
        sr = (s & mask(k)) >> 1;
        r  = '0;
        for (int i = 0; i < NC[k]; i++) begin
            code = RL[k][3*i +: 3];
            r[i] = s[i] ^ (USE_B[code] & sl[i]) ^ (USE_C[code] & sr[i])
                        ^ (USE_BC[code] & sl[i] & sr[i]);
        end
        return r;
    endfunction

    function automatic logic [31:0] got_at(input int i);
        return (got_q.size() > i) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF;
    endfunction

    // Called at a negedge; pulses start and checks the warm-up length until in_ready rises.
    task automatic do_start(input int k, input logic [31:0] seed_v, input logic with_valid);
        int cnt;
        st[k] = 1'b1;
        sd[k] = seed_v;
        iv[k] = with_valid;
        id[k] = 8'h00;
        #1;
        check("start_blocks_ready", ir[k], 0);
        @(negedge clk);
        st[k] = 1'b0;
        iv[k] = 1'b0;
        #1;
        check("load_out_valid", ov[k], 0);
        check("load_busy", bsy[k], 1);
        m_s[k] = seed_v & mask(k);
        if (m_s[k] == 0) m_s[k] = 32'd1;
        for (int j = 0; j < WU[k]; j++) m_s[k] = model_step(m_s[k], k);
        exp_q.delete();
        cnt = 0;
        while (!ir[k] && cnt < WU[k] + 20) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        check("warmup_len", cnt, WU[k] + 1);
    endtask

    // Drives src_q through instance k with random valid gaps and out_ready backpressure (bp %).
    task automatic stream(input int k, input int bp);
        int   sent;
        int   cyc;
        logic hold;
        sent = 0;
        cyc  = 0;
        hold = 1'b0;
        got_q.delete();
        while ((sent < src_q.size() || exp_q.size() > 0) && cyc < 4000) begin
            if (!hold) begin
                iv[k] = (sent < src_q.size()) && ($urandom_range(3) != 0);
                id[k] = (sent < src_q.size()) ? src_q[sent] : 8'($urandom);
            end
            ordy[k] = ($urandom_range(99) >= bp);
            #1;
            if (ov[k] && ordy[k]) begin
                if (exp_q.size() == 0) check("unexpected_out", 1, 0);
                else check("out_data", od[k], exp_q.pop_front());
                got_q.push_back(od[k]);
            end
            hold = iv[k] && !ir[k];
            if (iv[k] && ir[k]) begin
                exp_q.push_back(src_q[sent] ^ m_s[k][7:0]);
                m_s[k] = model_step(m_s[k], k);
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        iv[k] = 1'b0;
        check("stream_timeout", (cyc >= 4000), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            st[k] = 0; sd[k] = 0; iv[k] = 0; id[k] = 0; ordy[k] = 0; m_s[k] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_busy", bsy[k], 0);
            check("rst_in_ready", ir[k], 0);
            check("rst_out_valid", ov[k], 0);
            check("rst_out_data", od[k], 0);
        end
        @(negedge clk);

        // Rule 111 keeps the state constant.
        do_start(2, 32'h0000_00A5, 1'b0);
        src_q = {8'h3C, 8'hFF};
        stream(2, 0);
        check("const_n", got_q.size(), 2);
        check("const_b0", got_at(0), 32'h99);
        check("const_b1", got_at(1), 32'h5A);

        // Rule 001 on 8 cells.
        do_start(1, 32'h01, 1'b0);
        src_q = {8'h00, 8'h00, 8'h00};
        stream(1, 0);
        check("r001_n", got_q.size(), 3);
        check("r001_b0", got_at(0), 32'h05);
        check("r001_b1", got_at(1), 32'h0F);
        check("r001_b2", got_at(2), 32'h11);

        // Same stream, consumer stalls for 3 cycles after the first byte.
        do_start(1, 32'h01, 1'b0);
        iv[1] = 1'b1; id[1] = 8'h00; ordy[1] = 1'b0;
        #1;
        check("bp_first_ready", ir[1], 1);
        exp_q.push_back(8'h00 ^ m_s[1][7:0]);
        m_s[1] = model_step(m_s[1], 1);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            #1;
            check("bp_valid_held", ov[1], 1);
            check("bp_data_held", od[1], 32'h05);
            check("bp_ready_low", ir[1], 0);
            @(negedge clk);
        end
        iv[1] = 1'b0;
        src_q = {8'h00, 8'h00};
        stream(1, 0);
        check("bp_n", got_q.size(), 3);
        check("bp_b0", got_at(0), 32'h05);
        check("bp_b1", got_at(1), 32'h0F);
        check("bp_b2", got_at(2), 32'h11);

        // All-zero seed loads as 1.
        do_start(1, 32'h0, 1'b0);
        src_q = {8'h00};
        stream(1, 0);
        check("seed0_b0", got_at(0), 32'h05);

        // Restart in RUN with a pending output and in_valid high.
        do_start(1, 32'h01, 1'b0);
        iv[1] = 1'b1; id[1] = 8'h00; ordy[1] = 1'b0;
        #1;
        check("rs_ready", ir[1], 1);
        @(negedge clk);
        #1;
        check("rs_pending", ov[1], 1);
        check("rs_pending_data", od[1], 32'h05);
        do_start(1, 32'h01, 1'b1);
        src_q = {8'h00};
        stream(1, 0);
        check("rs_n", got_q.size(), 1);
        check("rs_b0", got_at(0), 32'h05);

        // Randomized streams on the mixed-rule instance.
        for (int r = 0; r < 3; r++) begin
            do_start(0, $urandom, 1'b0);
            src_q.delete();
            for (int j = 0; j < 40; j++) src_q.push_back(8'($urandom));
            stream(0, r * 30);
            check("rand_n", got_q.size(), 40);
        end

        // Asynchronous reset mid-RUN with a pending output.
        do_start(0, $urandom, 1'b0);
        iv[0] = 1'b1; id[0] = 8'($urandom); ordy[0] = 1'b0;
        #1;
        check("mr_ready", ir[0], 1);
        @(negedge clk);
        iv[0] = 1'b0;
        #1;
        check("mr_valid_before", ov[0], 1);
        #1 rst_n = 1'b0;
        #1;
        check("mr_valid", ov[0], 0);
        check("mr_ready_low", ir[0], 0);
        check("mr_busy", bsy[0], 0);
        check("mr_data", od[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            check("mr_ready_stays_low", ir[0], 0);
            @(negedge clk);
        end

        do_start(0, $urandom, 1'b0);
        src_q.delete();
        for (int j = 0; j < 20; j++) src_q.push_back(8'($urandom));
        stream(0, 20);
        check("post_rst_n", got_q.size(), 20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
